// File: rtl/quad_port_ram_write_arbiter_pkg.sv
// Shared constants and types for the quad-port RAM write arbiter.
// Default RAM geometry, state encoding and pair-counter width.
package quad_port_ram_write_arbiter_pkg;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int pair_w(input int aw);
    return aw - 1;
  endfunction

  localparam int PAIR_W = pair_w(AW);

endpackage

// File: rtl/quad_port_ram_write_arbiter_if.sv
// Write-request bus between requesters and the arbiter.
// One req/addr/data lane per requester, acked in the grant cycle.
interface quad_port_ram_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = quad_port_ram_write_arbiter_pkg::AW,
  parameter int DW   = quad_port_ram_write_arbiter_pkg::DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;

  modport master (
    output req,
    output req_addr,
    output req_data,
    input  ack
  );

  modport slave (
    input  req,
    input  req_addr,
    input  req_data,
    output ack
  );

endinterface

// File: rtl/quad_port_ram_write_arbiter_rr_pick.sv
// Round-robin first-set finder over an N-bit mask.
// Scans from start upward with wrap; reports the first set bit.
module quad_port_ram_write_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int s = 0; s < N; s++) begin
      j = IW'((int'(start) + s) % N);
      if (!found && mask[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/quad_port_ram_write_arbiter.sv
// Clears the RAM two words per cycle after reset, then grants
// up to two round-robin writes per cycle to distinct addresses.
module quad_port_ram_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = quad_port_ram_write_arbiter_pkg::AW,
  parameter int DW    = quad_port_ram_write_arbiter_pkg::DW,
  parameter int DEPTH = quad_port_ram_write_arbiter_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  quad_port_ram_write_arbiter_if.slave bus,
  output logic          ram_we_a,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic          ram_we_b,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          init_done
);

  import quad_port_ram_write_arbiter_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int KW = pair_w(AW);
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH / 2 - 1);

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  state_t        state;
  logic [KW-1:0] k;
  logic [IW-1:0] rr;

  logic [AW-1:0] addr_of [NREQ];
  logic [DW-1:0] data_of [NREQ];

  logic          fa;
  logic          fb;
  logic [IW-1:0] ia;
  logic [IW-1:0] ib;
  logic [IW-1:0] sb;
  logic [AW-1:0] aa;
  logic [NREQ-1:0] mb;
  logic          wa;
  logic          wb;
  logic [NREQ-1:0] ack_v;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_of[i] = bus.req_addr[i*AW +: AW];
      data_of[i] = bus.req_data[i*DW +: DW];
    end
  end

  quad_port_ram_write_arbiter_rr_pick #(
    .N (NREQ)
  ) u_pick_a (
    .mask  (bus.req),
    .start (rr),
    .found (fa),
    .idx   (ia)
  );

  assign aa = addr_of[ia];
  assign sb = nxt(ia);

  // Port b skips port a's winner and anyone aiming at its address.
  always_comb begin
    mb = '0;
    for (int i = 0; i < NREQ; i++) begin
      mb[i] = bus.req[i]
            && (IW'(i) != ia)
            && (addr_of[i] != aa);
    end
  end

  quad_port_ram_write_arbiter_rr_pick #(
    .N (NREQ)
  ) u_pick_b (
    .mask  (mb),
    .start (sb),
    .found (fb),
    .idx   (ib)
  );

  assign wa = (state == ST_RUN) && !reset && fa;
  assign wb = wa && fb;

  always_comb begin
    ack_v = '0;
    if (wa) ack_v = ack_v | (NREQ'(1) << ia);
    if (wb) ack_v = ack_v | (NREQ'(1) << ib);
  end

  assign bus.ack = ack_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      k          <= '0;
      rr         <= '0;
      ram_we_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
      ram_we_b   <= 1'b0;
      ram_addr_b <= '0;
      ram_data_b <= '0;
      init_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          ram_we_a   <= 1'b1;
          ram_we_b   <= 1'b1;
          ram_addr_a <= {k, 1'b0};
          ram_addr_b <= {k, 1'b1};
          ram_data_a <= '0;
          ram_data_b <= '0;
          k          <= k + KW'(1);
          if (k == K_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          ram_we_a <= wa;
          ram_we_b <= wb;
          if (wa) begin
            ram_addr_a <= aa;
            ram_data_a <= data_of[ia];
          end
          if (wb) begin
            ram_addr_b <= addr_of[ib];
            ram_data_b <= data_of[ib];
          end
          if (wb)      rr <= nxt(ib);
          else if (wa) rr <= nxt(ia);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_port_ram_write_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run
// against a grant/memory reference model.
module tb_quad_port_ram_write_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          we_a;
  logic          we_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          init_done;

  always #5 clk = ~clk;

  quad_port_ram_write_arbiter_if #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) bus ();

  quad_port_ram_write_arbiter #(
    .NREQ  (NREQ),
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ram_we_a   (we_a),
    .ram_addr_a (addr_a),
    .ram_data_a (data_a),
    .ram_we_b   (we_b),
    .ram_addr_b (addr_b),
    .ram_data_b (data_b),
    .init_done  (init_done)
  );

  // RAM stand-in; scrub fills it with garbage so clearing is visible.
  logic [DW-1:0] mem [DEPTH];
  logic          scrub = 1'b0;

  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hdeadbeef;
    end else begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
    end
  end

  int errs   = 0;
  int checks = 0;

  int            ptr;
  logic [3:0]    pend;
  int            paddr [NREQ];
  logic [DW-1:0] pdata [NREQ];
  logic [DW-1:0] exp_mem [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a,
                         input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    bus.req[i] = 1'b0;
  endtask

  // Grant rule: a = first requester from ptr; b = first after a
  // whose address differs from a's.
  function automatic void pick(output int a, output int b);
    int i;
    a = -1;
    b = -1;
    for (int s = 0; s < NREQ; s++) begin
      i = (ptr + s) % NREQ;
      if (a < 0 && pend[i]) a = i;
    end
    if (a >= 0) begin
      for (int s = 1; s < NREQ; s++) begin
        i = (a + s) % NREQ;
        if (b < 0 && pend[i] && paddr[i] != paddr[a]) b = i;
      end
    end
  endfunction

  task automatic test_reset();
    scrub = 1'b1;
    reset = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    set_req(3, 9, 7);
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b0000) begin
      errs++;
      $display("FAIL rst_ack got %b want 0000", bus.ack);
    end
    checks++;
    if ({we_a, we_b, addr_a, addr_b, data_a, data_b, init_done} !== '0) begin
      errs++;
      $display("FAIL rst_outs got we=%b%b a=%0d b=%0d id=%b want 0",
               we_a, we_b, addr_a, addr_b, init_done);
    end
    scrub = 1'b0;
    reset = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      @(negedge clk);
      checks++;
      if (bus.ack !== 4'b0000) begin
        errs++;
        $display("FAIL init_ack C%0d got %b want 0000", n, bus.ack);
      end
      checks++;
      if (init_done !== (n == 32)) begin
        errs++;
        $display("FAIL init_done C%0d got %b want %b",
                 n, init_done, n == 32);
      end
      if (n >= 1) begin
        checks++;
        if ({we_a, we_b} !== 2'b11
            || addr_a !== AW'(2*(n-1))
            || addr_b !== AW'(2*n-1)
            || data_a !== '0 || data_b !== '0) begin
          errs++;
          $display("FAIL init_pair C%0d got we=%b%b %0d/%0d want 11 %0d/%0d",
                   n, we_a, we_b, addr_a, addr_b, 2*(n-1), 2*n-1);
        end
      end
      @(posedge clk);
      #1;
      if (n == 31) clr_req(3);
    end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mem[i] !== '0) begin
        errs++;
        $display("FAIL init_clear addr=%0d got %h want 0", i, mem[i]);
      end
    end
  endtask

  task automatic test_single();
    set_req(2, 10, 11);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0100) begin
      errs++;
      $display("FAIL single_ack got %b want 0100", bus.ack);
    end
    tick();
    clr_req(2);
    checks++;
    if (we_a !== 1'b1 || addr_a !== 6'd10 || data_a !== 32'd11
        || we_b !== 1'b0 || addr_b !== 6'd63) begin
      errs++;
      $display("FAIL single_port got we=%b%b a=%0d d=%0d b=%0d want 10 a=10 d=11 b=63",
               we_a, we_b, addr_a, data_a, addr_b);
    end
    tick();
    checks++;
    if (mem[10] !== 32'd11) begin
      errs++;
      $display("FAIL single_ram got %0d want 11", mem[10]);
    end
    // Pointer now 3: r3 beats r2 on a shared address.
    set_req(2, 5, 7);
    set_req(3, 5, 8);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b1000) begin
      errs++;
      $display("FAIL ptr3_ack got %b want 1000", bus.ack);
    end
    tick();
    clr_req(3);
    checks++;
    if (addr_a !== 6'd5 || data_a !== 32'd8) begin
      errs++;
      $display("FAIL ptr3_port got %0d/%0d want 5/8", addr_a, data_a);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0100) begin
      errs++;
      $display("FAIL ptr3_ack2 got %b want 0100", bus.ack);
    end
    tick();
    clr_req(2);
    set_req(3, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b1000) begin
      errs++;
      $display("FAIL ptr_r3 got %b want 1000", bus.ack);
    end
    tick();
    clr_req(3);
    tick();
    checks++;
    if (mem[5] !== 32'd7) begin
      errs++;
      $display("FAIL ptr3_ram got %0d want 7", mem[5]);
    end
  endtask

  task automatic test_pairs();
    for (int i = 0; i < 4; i++) set_req(i, i + 1, 100 + i);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0011) begin
      errs++;
      $display("FAIL pairs_ack1 got %b want 0011", bus.ack);
    end
    tick();
    clr_req(0);
    clr_req(1);
    checks++;
    if ({we_a, we_b} !== 2'b11 || addr_a !== 6'd1 || addr_b !== 6'd2) begin
      errs++;
      $display("FAIL pairs_port1 got %b %0d/%0d want 11 1/2",
               {we_a, we_b}, addr_a, addr_b);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b1100) begin
      errs++;
      $display("FAIL pairs_ack2 got %b want 1100", bus.ack);
    end
    tick();
    clr_req(2);
    clr_req(3);
    checks++;
    if ({we_a, we_b} !== 2'b11 || addr_a !== 6'd3 || addr_b !== 6'd4) begin
      errs++;
      $display("FAIL pairs_port2 got %b %0d/%0d want 11 3/4",
               {we_a, we_b}, addr_a, addr_b);
    end
    tick();
  endtask

  task automatic test_conflict();
    set_req(0, 20, 5);
    set_req(1, 20, 2100100100);
    set_req(2, 22, 333);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0101) begin
      errs++;
      $display("FAIL conf_ack1 got %b want 0101", bus.ack);
    end
    tick();
    clr_req(0);
    clr_req(2);
    checks++;
    if (addr_a !== 6'd20 || data_a !== 32'd5
        || addr_b !== 6'd22 || data_b !== 32'd333) begin
      errs++;
      $display("FAIL conf_port1 got %0d=%0d %0d=%0d want 20=5 22=333",
               addr_a, data_a, addr_b, data_b);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0010) begin
      errs++;
      $display("FAIL conf_ack2 got %b want 0010", bus.ack);
    end
    tick();
    clr_req(1);
    checks++;
    if ({we_a, we_b} !== 2'b10 || data_a !== 32'd2100100100) begin
      errs++;
      $display("FAIL conf_port2 got %b %0d want 10 2100100100",
               {we_a, we_b}, data_a);
    end
    tick();
    checks++;
    if (mem[20] !== 32'd2100100100 || mem[22] !== 32'd333) begin
      errs++;
      $display("FAIL conf_ram got %0d/%0d want 2100100100/333",
               mem[20], mem[22]);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eack [4];
    int ea [4];
    int eb [4];
    eack = '{4'b0011, 4'b0101, 4'b0110, 4'b0011};
    ea = '{30, 32, 31, 30};
    eb = '{31, 30, 32, 31};
    set_req(3, 40, 1);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b1000) begin
      errs++;
      $display("FAIL fair_r3 got %b want 1000", bus.ack);
    end
    tick();
    clr_req(3);
    for (int i = 0; i < 3; i++) set_req(i, 30 + i, i);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ack !== eack[c]) begin
        errs++;
        $display("FAIL fair_ack c=%0d got %b want %b", c, bus.ack, eack[c]);
      end
      tick();
      checks++;
      if (addr_a !== AW'(ea[c]) || addr_b !== AW'(eb[c])) begin
        errs++;
        $display("FAIL fair_port c=%0d got %0d/%0d want %0d/%0d",
                 c, addr_a, addr_b, ea[c], eb[c]);
      end
    end
    for (int i = 0; i < 3; i++) clr_req(i);
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 10, 11);
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0001) begin
      errs++;
      $display("FAIL mid_ack got %b want 0001", bus.ack);
    end
    tick();
    clr_req(0);
    tick();
    checks++;
    if (mem[10] !== 32'd11) begin
      errs++;
      $display("FAIL mid_ram got %0d want 11", mem[10]);
    end
    set_req(0, 12, 1);
    set_req(1, 13, 2);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0000) begin
      errs++;
      $display("FAIL mid_rst_ack got %b want 0000", bus.ack);
    end
    tick();
    checks++;
    if ({we_a, we_b, init_done} !== 3'b000) begin
      errs++;
      $display("FAIL mid_rst_we got %b want 000", {we_a, we_b, init_done});
    end
    reset = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      checks++;
      if ({init_done, bus.ack} !== 5'b0) begin
        errs++;
        $display("FAIL mid_init C%0d got id=%b ack=%b want 0 0000",
                 n, init_done, bus.ack);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({init_done, bus.ack} !== 5'b1_0011) begin
      errs++;
      $display("FAIL mid_run got id=%b ack=%b want 1 0011",
               init_done, bus.ack);
    end
    tick();
    clr_req(0);
    clr_req(1);
    tick();
    checks++;
    if (mem[10] !== '0 || mem[12] !== 32'd1 || mem[13] !== 32'd2) begin
      errs++;
      $display("FAIL mid_ram2 got %0d/%0d/%0d want 0/1/2",
               mem[10], mem[12], mem[13]);
    end
  endtask

  task automatic test_random();
    int a;
    int b;
    logic [3:0] eack;
    ptr = 2;
    pend = '0;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          paddr[i] = int'($urandom_range(0, 7));
          pdata[i] = $urandom;
          set_req(i, paddr[i], pdata[i]);
        end
      end
      @(negedge clk);
      pick(a, b);
      eack = '0;
      if (a >= 0) eack = eack | (4'b0001 << a);
      if (b >= 0) eack = eack | (4'b0001 << b);
      checks++;
      if (bus.ack !== eack) begin
        errs++;
        $display("FAIL rnd_ack c=%0d got %b want %b", c, bus.ack, eack);
      end
      if (a >= 0) begin
        exp_mem[paddr[a]] = pdata[a];
        ptr = ((b >= 0 ? b : a) + 1) % NREQ;
      end
      if (b >= 0) exp_mem[paddr[b]] = pdata[b];
      tick();
      checks++;
      if ({we_a, we_b} !== {a >= 0, b >= 0}) begin
        errs++;
        $display("FAIL rnd_we c=%0d got %b%b want %b%b",
                 c, we_a, we_b, a >= 0, b >= 0);
      end
      if (a >= 0) begin
        checks++;
        if (addr_a !== AW'(paddr[a]) || data_a !== pdata[a]) begin
          errs++;
          $display("FAIL rnd_pa c=%0d got %0d=%h want %0d=%h",
                   c, addr_a, data_a, paddr[a], pdata[a]);
        end
        pend[a] = 1'b0;
        clr_req(a);
      end
      if (b >= 0) begin
        checks++;
        if (addr_b !== AW'(paddr[b]) || data_b !== pdata[b]) begin
          errs++;
          $display("FAIL rnd_pb c=%0d got %0d=%h want %0d=%h",
                   c, addr_b, data_b, paddr[b], pdata[b]);
        end
        pend[b] = 1'b0;
        clr_req(b);
      end
    end
    bus.req = '0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errs++;
        $display("FAIL rnd_ram addr=%0d got %h want %h",
                 i, mem[i], exp_mem[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pairs();
    test_conflict();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
